apb_controller: RTL and testbench

- APB-side master FSM of the AHB-to-APB bridge; consumes the transfer qualifier `valid` and the AHB address/data produced by the bridge's AHB slave interface.
- Turns each accepted AHB transfer into one APB setup + enable access.
- Drives `Hreadyout` back to the AHB bus to stall the master while the APB access runs, and returns read data and the response.

---
 rtl/apb_controller.sv | 201 ++++++++++++++++++++
 tb/tb_apb_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_controller.sv
// APB-side master FSM of the AHB-to-APB bridge.
// Each accepted AHB transfer becomes one APB setup + enable access. Hreadyout
// stalls the AHB master while the APB access runs.
// Optional build macro APB_PREADY_EN adds Pready/Pslverr wait-state and error
// handling (extra ERR state). The default build has neither.
module apb_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              valid,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic              Hwrite,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [DATA_W-1:0] Prdata,
`ifdef APB_PREADY_EN
   input  logic              Pready,
   input  logic              Pslverr,
`endif
   output logic [2:0]        Pselx,
   output logic              Penable,
   output logic              Pwrite,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Hreadyout,
   output logic [DATA_W-1:0] Hrdata,
   output logic [1:0]        Hresp
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RSETUP  = 3'd1;
   localparam logic [2:0] RENABLE = 3'd2;
   localparam logic [2:0] WWAIT   = 3'd3;
   localparam logic [2:0] WSETUP  = 3'd4;
   localparam logic [2:0] WENABLE = 3'd5;
`ifdef APB_PREADY_EN
   localparam logic [2:0] ERR     = 3'd6;
`endif

   logic [2:0]        state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [2:0]        pselx_q,   pselx_d;
   logic              penable_q, penable_d;
   logic              pwrite_q,  pwrite_d;
   logic [ADDR_W-1:0] paddr_q,   paddr_d;
   logic [DATA_W-1:0] pwdata_q,  pwdata_d;
   logic              hready_q,  hready_d;

   logic enable_st;
   logic done;
`ifdef APB_PREADY_EN
   logic slverr;
   logic err_q, err_d;
`endif

   // Peripheral decode: only the 0x8xxx_xxxx window selects a slave;
   // the fourth slot (a[27:26]=11) is unpopulated.
   function automatic logic [2:0] dec(input logic [ADDR_W-1:0] a);
      logic [2:0] sel;
      sel = 3'b000;
      if (a[31:28] == 4'h8) begin
         case (a[27:26])
            2'b00:   sel = 3'b001;
            2'b01:   sel = 3'b010;
            2'b10:   sel = 3'b100;
            default: sel = 3'b000;
         endcase
      end
      return sel;
   endfunction

   assign enable_st = (state_q == RENABLE) || (state_q == WENABLE);
`ifdef APB_PREADY_EN
   assign done   = Pready & ~Pslverr;
   assign slverr = enable_st & Pready & Pslverr;
`else
   assign done   = 1'b1;
`endif

   // Next-state and next-output logic; outputs are loaded on the edge that
   // enters the new state so they always reflect the current state.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pselx_d   = pselx_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      hready_d  = hready_q;
`ifdef APB_PREADY_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE, RENABLE, WENABLE: begin
            if ((state_q == IDLE) || done) begin
               if (valid) begin
                  addr_d    = Haddr;
                  penable_d = 1'b0;
                  hready_d  = 1'b0;
                  if (Hwrite) begin
                     state_d = WWAIT;
                     pselx_d = 3'b000;
                  end else begin
                     state_d  = RSETUP;
                     paddr_d  = Haddr;
                     pwrite_d = 1'b0;
                     pselx_d  = dec(Haddr);
                  end
               end else begin
                  state_d   = IDLE;
                  pselx_d   = 3'b000;
                  penable_d = 1'b0;
                  hready_d  = 1'b1;
               end
            end
`ifdef APB_PREADY_EN
            else if (slverr) begin
               state_d   = ERR;
               pselx_d   = 3'b000;
               penable_d = 1'b0;
               hready_d  = 1'b1;
               err_d     = 1'b1;
            end
`endif
         end
         RSETUP: begin
            state_d   = RENABLE;
            penable_d = 1'b1;
            hready_d  = 1'b1;
         end
         WWAIT: begin
            state_d   = WSETUP;
            paddr_d   = addr_q;
            pwdata_d  = Hwdata;
            pwrite_d  = 1'b1;
            pselx_d   = dec(addr_q);
            penable_d = 1'b0;
            hready_d  = 1'b0;
         end
         WSETUP: begin
            state_d   = WENABLE;
            penable_d = 1'b1;
            hready_d  = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            pselx_d   = 3'b000;
            penable_d = 1'b0;
            hready_d  = 1'b1;
         end
      endcase
   end

   // State and registered APB/AHB outputs.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         pselx_q   <= 3'b000;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         hready_q  <= 1'b1;
`ifdef APB_PREADY_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pselx_q   <= pselx_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         hready_q  <= hready_d;
`ifdef APB_PREADY_EN
         err_q     <= err_d;
`endif
      end
   end

   assign Pselx   = pselx_q;
   assign Penable = penable_q;
   assign Pwrite  = pwrite_q;
   assign Paddr   = paddr_q;
   assign Pwdata  = pwdata_q;
   assign Hrdata  = Prdata;
`ifdef APB_PREADY_EN
   // In the enable states ready follows the slave; an error response holds it
   // low for the first of its two cycles.
   assign Hreadyout = enable_st ? (Pready & ~Pslverr) : hready_q;
   assign Hresp     = (err_q || slverr) ? 2'b01 : 2'b00;
`else
   assign Hreadyout = hready_q;
   assign Hresp     = 2'b00;
`endif

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller (default build): directed scenarios followed by
// random traffic, compared every cycle against a transfer-level plan model.
module tb_apb_controller;

   logic        Hclk = 1'b0;
   logic        Hreset;
   logic        valid;
   logic [31:0] Haddr;
   logic        Hwrite;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Hreadyout;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;

   int checks = 0;
   int errors = 0;

   apb_controller #(.ADDR_W(32), .DATA_W(32)) dut (
      .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr),
      .Hwrite(Hwrite), .Hwdata(Hwdata), .Prdata(Prdata),
      .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
      .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
   );

   always #5 Hclk = ~Hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One planned APB-side cycle of a transfer.
   typedef struct {
      logic [2:0]  sel;
      logic        en;
      logic        hr;
      logic        set_addr;
      logic [31:0] addr;
      logic        set_wr;
      logic        wr;
      logic        take_wdata;
   } step_t;

   step_t plan[$];

   logic [2:0]  exp_sel;
   logic        exp_en, exp_wr, exp_hr;
   logic [31:0] exp_addr, exp_wdata;
   logic        chk_en = 1'b0;

   function automatic logic [2:0] slave_of(input logic [31:0] a);
      int idx;
      if (a[31:28] != 4'h8) return 3'b000;
      idx = int'(a[27:26]);
      if (idx == 3) return 3'b000;
      return 3'(1 << idx);
   endfunction

   // Reference model: an accepted transfer queues its whole cycle sequence;
   // a new transfer can only be taken when nothing is left in the plan
   // (idle or completion cycle).
   always @(posedge Hclk) begin
      step_t s;
      if (Hreset) begin
         plan.delete();
         exp_sel <= 3'b000; exp_en <= 1'b0; exp_wr <= 1'b0; exp_hr <= 1'b1;
         exp_addr <= 32'h0; exp_wdata <= 32'h0;
         chk_en <= 1'b1;
      end else begin
         if (plan.size() == 0 && valid) begin
            if (Hwrite) begin
               plan.push_back('{3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
               plan.push_back('{slave_of(Haddr), 1'b0, 1'b0, 1'b1, Haddr, 1'b1, 1'b1, 1'b1});
               plan.push_back('{slave_of(Haddr), 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
            end else begin
               plan.push_back('{slave_of(Haddr), 1'b0, 1'b0, 1'b1, Haddr, 1'b1, 1'b0, 1'b0});
               plan.push_back('{slave_of(Haddr), 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
            end
         end
         if (plan.size() != 0) begin
            s = plan.pop_front();
            exp_sel <= s.sel; exp_en <= s.en; exp_hr <= s.hr;
            if (s.set_addr)   exp_addr  <= s.addr;
            if (s.set_wr)     exp_wr    <= s.wr;
            if (s.take_wdata) exp_wdata <= Hwdata;
         end else begin
            exp_sel <= 3'b000; exp_en <= 1'b0; exp_hr <= 1'b1;
         end
      end
   end

   // Compare every output mid-cycle.
   always @(negedge Hclk) begin
      if (chk_en) begin
         check("Pselx", 32'(Pselx), 32'(exp_sel));
         check("Penable", 32'(Penable), 32'(exp_en));
         check("Pwrite", 32'(Pwrite), 32'(exp_wr));
         check("Paddr", Paddr, exp_addr);
         check("Pwdata", Pwdata, exp_wdata);
         check("Hreadyout", 32'(Hreadyout), 32'(exp_hr));
         check("Hrdata", Hrdata, Prdata);
         check("Hresp", 32'(Hresp), 32'h0);
      end
   end

   task automatic cyc(input logic rst, input logic v, input logic [31:0] a,
                      input logic w, input logic [31:0] d, input logic [31:0] pr);
      Hreset = rst; valid = v; Haddr = a; Hwrite = w; Hwdata = d; Prdata = pr;
      @(posedge Hclk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      Hreset = 1'b1; valid = 1'b0; Haddr = '0; Hwrite = 1'b0; Hwdata = '0; Prdata = '0;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // single read
      cyc(0, 1, 32'h8400_0010, 0, 0, 32'hCAFE_F00D);
      repeat (3) cyc(0, 0, 0, 0, 0, 32'hCAFE_F00D);
      // single write
      cyc(0, 1, 32'h8800_0004, 1, 0, 0);
      repeat (4) cyc(0, 0, 0, 0, 32'h1234_5678, 0);
      // back-to-back write then read accepted in the write's enable cycle
      cyc(0, 1, 32'h8000_0000, 1, 0, 0);
      cyc(0, 0, 0, 0, 32'hAAAA_5555, 0);
      cyc(0, 0, 0, 0, 32'hAAAA_5555, 0);
      cyc(0, 1, 32'h8000_0008, 0, 32'hAAAA_5555, 32'h1111_2222);
      repeat (3) cyc(0, 0, 0, 0, 0, 32'h3333_4444);
      // unpopulated slot: FSM walks, nothing selected
      cyc(0, 1, 32'h8C00_0000, 0, 0, 0);
      cyc(0, 1, 32'h8C00_0000, 1, 0, 0);
      repeat (4) cyc(0, 0, 0, 0, 32'h5A5A_5A5A, 0);
      // reset while in the write setup cycle
      cyc(0, 1, 32'h8400_0004, 1, 0, 0);
      cyc(0, 0, 0, 0, 32'hDEAD_BEEF, 0);
      cyc(1, 0, 0, 0, 32'hDEAD_BEEF, 0);
      cyc(1, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[31:28] = 4'h8;
         d = $urandom;
         cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), a,
             1'($urandom_range(0, 1)), d, $urandom);
      end
      repeat (4) cyc(0, 0, 0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
